// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_arb_pkg
// Brief  : Shared types and requester indices for the cache memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package cache_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    // Words per burst; a block narrower than one word still moves one beat.
    function automatic int calc_beats(input int offset_width);
        return (offset_width > 2) ? (1 << (offset_width - 2)) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_beat_timer.sv
`default_nettype none
// ============================================================================
// Module : arb_beat_timer
// Brief  : Wait-state and beat counters for one memory burst.
// Rev    : 1.0  initial release
// ============================================================================
module arb_beat_timer #(
    parameter int BEATS       = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_beat_done,
    output logic o_last_beat
);

    localparam int WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [WAIT_W-1:0] r_wait_cnt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              w_wait_max;

    assign w_wait_max  = (r_wait_cnt == WAIT_W'(WAIT_STATES));
    assign o_beat_done = i_run && w_wait_max;
    assign o_last_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));

    // Clear wins over run so an abort or final beat always restarts from zero.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wait_cnt <= '0;
            r_beat_cnt <= '0;
        end else if (i_run) begin
            if (w_wait_max) begin
                r_wait_cnt <= '0;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cache_mem_arbiter
// Brief  : Round-robin arbiter sharing one memory port between I- and D-cache.
// Rev    : 1.0  initial release
// ============================================================================
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int OFFSET_WIDTH = 4,
    parameter int WAIT_STATES  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_i,
    input  logic [1:0]       wen_i,
    input  logic [1:0][31:0] addr_i,
    input  logic [1:0][31:0] wdata_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       ack_o,
    output logic             last_o,
    output logic [31:0]      rdata_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             mem_wen_o,
    input  logic [31:0]      mem_rdata_i,
    output logic             stall_o
);

    localparam int BEATS = calc_beats(OFFSET_WIDTH);

    arb_state_t r_state;
    logic       r_owner;
    logic       r_rr_ptr;

    logic w_active;
    logic w_owner_req;
    logic w_run;
    logic w_ack;
    logic w_last_beat;
    logic w_last_ack;
    logic w_clear;

    assign w_active    = (r_state == ACTIVE);
    assign w_owner_req = req_i[r_owner];
    // Reset gating keeps a reset cycle from acking or writing memory.
    assign w_run       = w_active && w_owner_req && !rst_i;
    assign w_last_ack  = w_ack && w_last_beat;
    assign w_clear     = !w_active || !w_owner_req || w_last_ack;

    arb_beat_timer #(
        .BEATS       (BEATS),
        .WAIT_STATES (WAIT_STATES)
    ) u_beat_timer (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_clear     (w_clear),
        .i_run       (w_run),
        .o_beat_done (w_ack),
        .o_last_beat (w_last_beat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_i) begin
                        r_state <= ACTIVE;
                        r_owner <= (&req_i) ? r_rr_ptr : req_i[REQ_D];
                    end
                end
                ACTIVE: begin
                    // Both abort and burst completion hand priority to the other cache.
                    if (!w_owner_req || w_last_ack) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= ~r_owner;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt_o       = w_active ? (2'b01 << r_owner) : 2'b00;
    assign ack_o       = w_ack ? (2'b01 << r_owner) : 2'b00;
    assign last_o      = w_last_ack;
    assign rdata_o     = mem_rdata_i;
    assign mem_addr_o  = w_active ? addr_i[r_owner] : 32'h0;
    assign mem_wdata_o = w_active ? wdata_i[r_owner] : 32'h0;
    assign mem_wen_o   = w_ack && wen_i[r_owner];
    assign stall_o     = (|req_i) || w_active;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_mem_arbiter
// Brief  : Directed self-checking bench for cache_mem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with WAIT_STATES=1
    logic             rst;
    logic [1:0]       req, wen;
    logic [1:0][31:0] addr, wdata;
    logic [31:0]      mrdata;
    logic [1:0]       gnt, ack;
    logic             last, mwen, stall;
    logic [31:0]      rdata, maddr, mwdata;

    // Instance with WAIT_STATES=0
    logic             rst_z;
    logic [1:0]       req_z, wen_z;
    logic [1:0][31:0] addr_z, wdata_z;
    logic [1:0]       gnt_z, ack_z;
    logic             last_z, mwen_z, stall_z;
    logic [31:0]      rdata_z, maddr_z, mwdata_z;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int k;

    cache_mem_arbiter #(.OFFSET_WIDTH(4), .WAIT_STATES(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .ack_o(ack),
        .last_o(last), .rdata_o(rdata), .mem_addr_o(maddr),
        .mem_wdata_o(mwdata), .mem_wen_o(mwen), .mem_rdata_i(mrdata),
        .stall_o(stall)
    );

    cache_mem_arbiter #(.OFFSET_WIDTH(4), .WAIT_STATES(0)) dut_z (
        .clk_i(clk), .rst_i(rst_z), .req_i(req_z), .wen_i(wen_z),
        .addr_i(addr_z), .wdata_i(wdata_z), .gnt_o(gnt_z), .ack_o(ack_z),
        .last_o(last_z), .rdata_o(rdata_z), .mem_addr_o(maddr_z),
        .mem_wdata_o(mwdata_z), .mem_wen_o(mwen_z), .mem_rdata_i(mrdata),
        .stall_o(stall_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        req = 2'b00;
        wen = 2'b00;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;  req = '0;   wen = '0;   addr = '0;   wdata = '0;
        rst_z = 1'b1; req_z = '0; wen_z = '0; addr_z = '0; wdata_z = '0;
        mrdata = 32'h0;

        // Reset held with random stimulus
        for (int i = 0; i < 2; i++) begin
            req   = 2'($urandom_range(3));
            wen   = 2'($urandom_range(3));
            addr  = {$urandom(), $urandom()};
            wdata = {$urandom(), $urandom()};
            tick();
            #1;
            chk("rst_ctl", 32'({gnt, ack, last, mwen}), 32'h0);
            chk("rst_bus", maddr | mwdata, 32'h0);
            chk("rst_stall", 32'(stall), 32'(|req));
            chk("rst_ctl_z", 32'({gnt_z, ack_z, last_z, mwen_z}), 32'h0);
        end
        req = '0; wen = '0; rst = 1'b0; rst_z = 1'b0;
        tick();

        // I-cache read burst
        mrdata  = 32'hCAFE_0001;
        addr[0] = 32'h40;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            req = (c <= 8) ? 2'b01 : 2'b00;
            #1;
            chk("t2_gnt", 32'(gnt), (c >= 1 && c <= 8) ? 32'h1 : 32'h0);
            chk("t2_ack", 32'(ack), (c == 2 || c == 4 || c == 6 || c == 8) ? 32'h1 : 32'h0);
            chk("t2_last", 32'(last), (c == 8) ? 32'h1 : 32'h0);
            chk("t2_stall", 32'(stall), (c <= 8) ? 32'h1 : 32'h0);
            if (c == 8) chk("t2_rdata", rdata, 32'hCAFE_0001);
        end

        // Contention: both request right after reset
        pulse_reset();
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) tick();
            req = {(c <= 17), (c <= 8)};
            #1;
            chk("t3_gnt", 32'(gnt), (c >= 1 && c <= 8) ? 32'h1 :
                                   (c >= 10 && c <= 17) ? 32'h2 : 32'h0);
            chk("t3_ack", 32'(ack), (c == 2 || c == 4 || c == 6 || c == 8) ? 32'h1 :
                                   (c == 11 || c == 13 || c == 15 || c == 17) ? 32'h2 : 32'h0);
            chk("t3_last", 32'(last), (c == 8 || c == 17) ? 32'h1 : 32'h0);
        end

        // D-cache write-back with stepped addresses; I-side data must never leak
        pulse_reset();
        pulses = 0;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            k        = (c <= 2) ? 0 : (c - 1) / 2;
            req      = (c <= 8) ? 2'b10 : 2'b00;
            wen      = 2'b11;
            addr[0]  = 32'hBAD0;
            wdata[0] = 32'hBAD1;
            addr[1]  = 32'h100 + 32'(4 * k);
            wdata[1] = 32'hD000_0000 + 32'(k);
            #1;
            if (mwen) pulses++;
            chk("t4_wen", 32'(mwen), (c == 2 || c == 4 || c == 6 || c == 8) ? 32'h1 : 32'h0);
            chk("t4_addr", maddr, (c >= 1 && c <= 8) ? 32'h100 + 32'(4 * k) : 32'h0);
            chk("t4_wdata", mwdata, (c >= 1 && c <= 8) ? 32'hD000_0000 + 32'(k) : 32'h0);
        end
        chk("t4_pulses", 32'(pulses), 32'd4);

        // Abort: I drops at c3, re-requests at c4 alongside pending D
        pulse_reset();
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) tick();
            req = {1'b1, (c != 3)};
            #1;
            chk("t5_gnt", 32'(gnt), (c >= 1 && c <= 3) ? 32'h1 :
                                   (c >= 5) ? 32'h2 : 32'h0);
            chk("t5_ack", 32'(ack), (c == 2) ? 32'h1 : (c == 6) ? 32'h2 : 32'h0);
            if (c == 4) chk("t5_addr_idle", maddr, 32'h0);
        end
        pulse_reset();

        // Zero wait states: mid-burst reset, then a clean back-to-back burst
        wen_z      = 2'b10;
        addr_z[1]  = 32'h200;
        wdata_z[1] = 32'h5A5A_0000;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            rst_z = (c == 3);
            req_z = (c <= 3 || (c >= 5 && c <= 9)) ? 2'b10 : 2'b00;
            #1;
            if (c != 3)
                chk("t6_gnt", 32'(gnt_z), ((c >= 1 && c <= 2) || (c >= 6 && c <= 9)) ? 32'h2 : 32'h0);
            chk("t6_ack", 32'(ack_z), (c == 1 || c == 2 || (c >= 6 && c <= 9)) ? 32'h2 : 32'h0);
            chk("t6_wen", 32'(mwen_z), (c == 1 || c == 2 || (c >= 6 && c <= 9)) ? 32'h1 : 32'h0);
            chk("t6_last", 32'(last_z), (c == 9) ? 32'h1 : 32'h0);
            if (c == 4) begin
                chk("t6_rst_ctl", 32'({gnt_z, ack_z, last_z, mwen_z, stall_z}), 32'h0);
                chk("t6_rst_bus", maddr_z | mwdata_z, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
